// File: rtl/pg_port_rst_sequencer.sv
// pg_port_rst_sequencer: per-port soft-reset controller for the port gasket.
// Each port has its own sequence RUN -> DRAIN -> ASSERT -> WAIT_REL -> RUN.
// A request first lets the TX A and TX B packets in flight finish. The port is
// then held in reset for HOLD_CYCLES cycles, and it is released once the
// request drops.
// Optional feature: define PG_RST_DRAIN_TIMEOUT_EN to force the reset after
// DRAIN_TIMEOUT drain cycles and flag it on drain_err.
// Ports:
//   clk, rst_n        clock; synchronous active-low global reset
//   rst_req           per-port soft-reset request (level)
//   tx_{a,b}_tvalid   per-port AFU->FIM stream handshake and tlast
//   tx_{a,b}_tready
//   tx_{a,b}_tlast
//   tx_block          1 = integrator blocks the port's TX streams
//   port_rst_n        active-low port reset
//   rst_ack           1 = port in reset, waiting for the request to drop
//   drain_err         sticky: drain timed out and the reset cut a packet
module pg_port_rst_sequencer #(
  parameter int unsigned NUM_PORTS     = 1,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] rst_req,
  input  logic [NUM_PORTS-1:0] tx_a_tvalid,
  input  logic [NUM_PORTS-1:0] tx_a_tready,
  input  logic [NUM_PORTS-1:0] tx_a_tlast,
  input  logic [NUM_PORTS-1:0] tx_b_tvalid,
  input  logic [NUM_PORTS-1:0] tx_b_tready,
  input  logic [NUM_PORTS-1:0] tx_b_tlast,
  output logic [NUM_PORTS-1:0] tx_block,
  output logic [NUM_PORTS-1:0] port_rst_n,
  output logic [NUM_PORTS-1:0] rst_ack,
  output logic [NUM_PORTS-1:0] drain_err
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
`ifdef PG_RST_DRAIN_TIMEOUT_EN
  localparam int unsigned DRAIN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ASSERT   = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              a_pkt_q, a_pkt_d, b_pkt_q, b_pkt_d;
    logic              a_trk, b_trk;
    logic              rstn_q, rstn_d, blk_q, blk_d, ack_q, ack_d;
    logic              timeout_hit;

    // Next state, hold counter, packet tracking and next output values
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      // In-packet flags as they will stand after this cycle's accepted beats
      a_trk = (tx_a_tvalid[p] & tx_a_tready[p]) ? ~tx_a_tlast[p] : a_pkt_q;
      b_trk = (tx_b_tvalid[p] & tx_b_tready[p]) ? ~tx_b_tlast[p] : b_pkt_q;
      case (state_q)
        ST_RUN:      if (rst_req[p]) state_d = ST_DRAIN;
        // The request is latched here, so rst_req is not looked at
        ST_DRAIN:    if (!(a_pkt_q | b_pkt_q) || timeout_hit) state_d = ST_ASSERT;
        ST_ASSERT: begin
          if (hold_q == '0) state_d = ST_WAIT_REL;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
        ST_WAIT_REL: if (!rst_req[p]) state_d = ST_RUN;
        default:     state_d = ST_ASSERT;
      endcase
      if ((state_d == ST_ASSERT) && (state_q != ST_ASSERT)) hold_d = HOLD_LOAD;
      // Reset discards any packet still open
      a_pkt_d = (state_d == ST_ASSERT) ? 1'b0 : a_trk;
      b_pkt_d = (state_d == ST_ASSERT) ? 1'b0 : b_trk;
      rstn_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      ack_d   = (state_d == ST_WAIT_REL);
      // While draining, keep the port open until both packets have closed
      blk_d   = (state_d != ST_RUN) && !((state_d == ST_DRAIN) && (a_pkt_d | b_pkt_d));
    end

    // State and registered outputs; global reset enters the hold phase
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_ASSERT;
        hold_q  <= HOLD_LOAD;
        a_pkt_q <= 1'b0;
        b_pkt_q <= 1'b0;
        rstn_q  <= 1'b0;
        blk_q   <= 1'b1;
        ack_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        a_pkt_q <= a_pkt_d;
        b_pkt_q <= b_pkt_d;
        rstn_q  <= rstn_d;
        blk_q   <= blk_d;
        ack_q   <= ack_d;
      end
    end

    assign port_rst_n[p] = rstn_q;
    assign tx_block[p]   = blk_q;
    assign rst_ack[p]    = ack_q;

`ifdef PG_RST_DRAIN_TIMEOUT_EN
    logic [DRAIN_W-1:0] drn_q, drn_d;
    logic               err_q, err_d;

    assign timeout_hit = (drn_q == DRAIN_LAST);

    // Drain age counter and sticky error; both restart on a new request
    always_comb begin
      drn_d = drn_q;
      err_d = err_q;
      if ((state_q == ST_RUN) && (state_d == ST_DRAIN)) begin
        drn_d = '0;
        err_d = 1'b0;
      end else if (state_q == ST_DRAIN) begin
        if (timeout_hit && (a_pkt_q | b_pkt_q)) err_d = 1'b1;
        else if (!timeout_hit)                  drn_d = drn_q + DRAIN_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        drn_q <= '0;
        err_q <= 1'b0;
      end else begin
        drn_q <= drn_d;
        err_q <= err_d;
      end
    end

    assign drain_err[p] = err_q;
`else
    // Without the timeout, drain waits indefinitely and the error never sets
    assign timeout_hit  = 1'b0;
    assign drain_err[p] = 1'b0 & (DRAIN_TIMEOUT == 0);
`endif
  end

endmodule

// File: tb/tb_pg_port_rst_sequencer.sv
// Bench for pg_port_rst_sequencer with two ports, HOLD_CYCLES=16 and
// DRAIN_TIMEOUT=64.
// A cycle-level reference model of the port reset sequence is checked against
// every output on every clock. Directed scenarios pin the latencies with
// literal cycle counts.
module tb_pg_port_rst_sequencer;
  localparam int unsigned NP   = 2;
  localparam int unsigned HOLD = 16;
  localparam int unsigned DT   = 64;
`ifdef PG_RST_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int M_RUN = 0, M_DRAIN = 1, M_HOLD = 2, M_WAIT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NP-1:0] rst_req, a_v, a_r, a_l, b_v, b_r, b_l;
  logic [NP-1:0] tx_block, port_rst_n, rst_ack, drain_err;

  int errors = 0;
  int checks = 0;

  pg_port_rst_sequencer #(
    .NUM_PORTS    (NP),
    .HOLD_CYCLES  (HOLD),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_req    (rst_req),
    .tx_a_tvalid(a_v),
    .tx_a_tready(a_r),
    .tx_a_tlast (a_l),
    .tx_b_tvalid(b_v),
    .tx_b_tready(b_r),
    .tx_b_tlast (b_l),
    .tx_block   (tx_block),
    .port_rst_n (port_rst_n),
    .rst_ack    (rst_ack),
    .drain_err  (drain_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sequence phase, remaining hold cycles, drain age, open packets
  int m_mode[NP];
  int m_left[NP];
  int m_age[NP];
  bit m_oa[NP], m_ob[NP], m_err[NP];
  bit na, nb;

  always begin
    @(posedge clk);
    for (int p = 0; p < NP; p++) begin
      if (!rst_n) begin
        m_mode[p] = M_HOLD; m_left[p] = HOLD; m_age[p] = 0;
        m_oa[p] = 1'b0; m_ob[p] = 1'b0; m_err[p] = 1'b0;
      end else begin
        na = (a_v[p] && a_r[p]) ? !a_l[p] : m_oa[p];
        nb = (b_v[p] && b_r[p]) ? !b_l[p] : m_ob[p];
        case (m_mode[p])
          M_RUN: if (rst_req[p]) begin m_mode[p] = M_DRAIN; m_age[p] = 0; m_err[p] = 1'b0; end
          M_DRAIN: begin
            if (!m_oa[p] && !m_ob[p]) begin
              m_mode[p] = M_HOLD; m_left[p] = HOLD;
            end else if (TO_EN && m_age[p] == DT - 1) begin
              m_mode[p] = M_HOLD; m_left[p] = HOLD; m_err[p] = 1'b1;
            end else m_age[p]++;
          end
          M_HOLD: begin
            m_left[p]--;
            if (m_left[p] == 0) m_mode[p] = M_WAIT;
          end
          default: if (!rst_req[p]) m_mode[p] = M_RUN;
        endcase
        m_oa[p] = (m_mode[p] == M_HOLD) ? 1'b0 : na;
        m_ob[p] = (m_mode[p] == M_HOLD) ? 1'b0 : nb;
      end
    end
    #2;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("model_port_rst_n[%0d]", p), 32'(port_rst_n[p]),
          32'(m_mode[p] == M_RUN || m_mode[p] == M_DRAIN));
      chk($sformatf("model_tx_block[%0d]", p), 32'(tx_block[p]),
          32'((m_mode[p] == M_RUN) ? 1'b0 :
              (m_mode[p] == M_DRAIN) ? !(m_oa[p] || m_ob[p]) : 1'b1));
      chk($sformatf("model_rst_ack[%0d]", p), 32'(rst_ack[p]), 32'(m_mode[p] == M_WAIT));
      chk($sformatf("model_drain_err[%0d]", p), 32'(drain_err[p]), 32'(m_err[p]));
    end
  end

  // Count negedges until the chosen output (0 port_rst_n, 1 tx_block, 2 rst_ack) equals val
  task automatic wait_for(input int sel, input int p, input logic val, output int n);
    logic s;
    n = 0;
    forever begin
      case (sel)
        0:       s = port_rst_n[p];
        1:       s = tx_block[p];
        default: s = rst_ack[p];
      endcase
      if (s === val || n >= 300) break;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, n1;
    rst_n = 1'b0; rst_req = '0;
    a_v = '0; a_r = '1; a_l = '0;
    b_v = '0; b_r = '1; b_l = '0;
    repeat (4) @(negedge clk);

    // Power-on: held in reset HOLD+1 cycles after rst_n rises
    rst_n = 1'b1;
    wait_for(0, 0, 1'b1, n);
    chk("t1_rst_low_cycles", n, 17);
    chk("t1_tx_block_open", tx_block[0], 0);
    chk("t1_port1_run", port_rst_n[1], 1);

    // Idle port soft reset
    repeat (2) @(negedge clk);
    rst_req[0] = 1'b1;
    wait_for(0, 0, 1'b0, n);
    chk("t2_req_to_rst", n, 2);
    wait_for(2, 0, 1'b1, n);
    chk("t2_rst_to_ack", n, 16);
    repeat (3) @(negedge clk);
    chk("t2_ack_held", rst_ack[0], 1);
    rst_req[0] = 1'b0;
    wait_for(0, 0, 1'b1, n);
    chk("t2_release", n, 1);
    chk("t2_ack_drop", rst_ack[0], 0);

    // 8-beat TX A packet, request arrives with beat 3
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a_v[0] = 1'b1;
      a_l[0] = (i == 7);
      if (i == 3) rst_req[0] = 1'b1;
      if (i >= 4) chk("t3_open_mid_pkt", tx_block[0], 0);
      if (i < 7) @(negedge clk);
    end
    wait_for(1, 0, 1'b1, n1);
    a_v[0] = 1'b0; a_l[0] = 1'b0;
    chk("t3_tlast_to_block", n1, 1);
    wait_for(0, 0, 1'b0, n);
    chk("t3_tlast_to_rst", n1 + n, 2);
    wait_for(2, 0, 1'b1, n);
    rst_req[0] = 1'b0;
    wait_for(0, 0, 1'b1, n);

    // Two ports: port 1 has TX B open, port 0 had a single-beat and a refused beat
    @(negedge clk);
    b_v[1] = 1'b1; b_l[1] = 1'b0; a_v[0] = 1'b1; a_l[0] = 1'b1;
    @(negedge clk);
    b_v[1] = 1'b0; a_l[0] = 1'b0; a_r[0] = 1'b0;
    @(negedge clk);
    rst_req = 2'b11;
    wait_for(0, 0, 1'b0, n);
    chk("t4_idle_port_first", n, 2);
    chk("t4_busy_port_run", port_rst_n[1], 1);
    chk("t4_busy_port_open", tx_block[1], 0);
    a_v[0] = 1'b0; a_r[0] = 1'b1;
    rst_req[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_drain_latched", port_rst_n[1], 1);
    b_v[1] = 1'b1; b_l[1] = 1'b1;
    @(negedge clk);
    b_v[1] = 1'b0; b_l[1] = 1'b0;
    wait_for(0, 1, 1'b0, n);
    chk("t4_busy_port_rst", n, 1);
    wait_for(2, 1, 1'b1, n);
    chk("t4_busy_port_ack", n, 16);
    @(negedge clk);
    chk("t4_ack_one_cycle", rst_ack[1], 0);
    chk("t4_busy_port_back", port_rst_n[1], 1);
    chk("t4_port0_waiting", rst_ack[0], 1);
    rst_req[0] = 1'b0;
    wait_for(0, 0, 1'b1, n);
    chk("t4_port0_release", n, 1);

    // TX A stalled mid-packet while draining
    @(negedge clk);
    a_v[0] = 1'b1; a_l[0] = 1'b0;
    @(negedge clk);
    a_r[0] = 1'b0;
    rst_req[0] = 1'b1;
`ifdef PG_RST_DRAIN_TIMEOUT_EN
    wait_for(0, 0, 1'b0, n);
    chk("t5_timeout_cycles", n, 65);
    chk("t5_err_set", drain_err[0], 1);
    a_v[0] = 1'b0; a_r[0] = 1'b1;
    wait_for(2, 0, 1'b1, n);
    rst_req[0] = 1'b0;
    wait_for(0, 0, 1'b1, n);
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", drain_err[0], 1);
    rst_req[0] = 1'b1;
    @(negedge clk);
    chk("t5_err_clear", drain_err[0], 0);
`else
    repeat (100) @(negedge clk);
    chk("t5_no_timeout", port_rst_n[0], 1);
    chk("t5_no_err", drain_err[0], 0);
    a_r[0] = 1'b1; a_l[0] = 1'b1;
    @(negedge clk);
    a_v[0] = 1'b0; a_l[0] = 1'b0;
    wait_for(0, 0, 1'b0, n);
    chk("t5_late_tlast_rst", n, 1);
`endif
    wait_for(2, 0, 1'b1, n);
    rst_req[0] = 1'b0;
    wait_for(0, 0, 1'b1, n);

    // Global reset in the middle of the hold phase restarts a full hold
    @(negedge clk);
    rst_req[0] = 1'b1;
    wait_for(0, 0, 1'b0, n);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_rst_in_hold", port_rst_n[0], 0);
    wait_for(2, 0, 1'b1, n);
    chk("t6_full_hold", n, 16);
    wait_for(0, 1, 1'b1, n);
    chk("t6_idle_port_run", n, 1);
    rst_req[0] = 1'b0;
    wait_for(0, 0, 1'b1, n);
    chk("t6_release", n, 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
